// File: rtl/return_stack.sv
`default_nettype none
// ============================================================================
// Module      : return_stack
// Description : Hardware return-address stack sitting beside the PC. A call
//               pushes the return address; a return pops it and the block
//               presents the address on `out` with a one-cycle `load` strobe
//               that drives the PC's in/load inputs directly.
//
// Parameters  : DEPTH - number of stack entries (power of two, >= 2)
//               WIDTH - address width (matches the PC width)
//
// Ports       : clock  in   system clock, rising-edge active
//               reset  in   asynchronous, active-high reset
//               push   in   store `in` on top of the stack this cycle
//               pop    in   remove top of stack this cycle
//               in     in   return address to push [WIDTH]
//               out    out  last popped address (to PC in) [WIDTH]
//               load   out  one-cycle strobe after an accepted pop (PC load)
//               count  out  number of valid entries [$clog2(DEPTH+1)]
//               empty  out  count == 0
//               full   out  count == DEPTH
//               err    out  sticky overflow/underflow flag
//
// Build macro : RETURN_STACK_WRAP_EN
//               undefined - a push while full is rejected and sets err.
//               defined   - storage is circular with a base pointer; a push
//                           while full overwrites the oldest entry, count
//                           saturates at DEPTH and err is not set. Underflow
//                           still sets err.
//
// Revision    : 1.0 - initial release
// ============================================================================
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 16
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             in,
  output logic [WIDTH-1:0]             out,
  output logic                         load,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         full,
  output logic                         err
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH + 1);

  localparam logic [c_ptr_w-1:0] c_ptr_one  = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_cnt_w-1:0] r_count;
  logic [WIDTH-1:0]   r_out;
  logic               r_load;
  logic               r_err;

  // --------------------------------------------------------------------------
  // Combinational decode
  // --------------------------------------------------------------------------
  logic               w_empty;
  logic               w_full;
  logic [c_ptr_w-1:0] w_base;
  logic [c_ptr_w-1:0] w_cnt_lo;
  logic [c_ptr_w-1:0] w_wr_idx;
  logic [c_ptr_w-1:0] w_top_idx;

  logic               w_mem_we;
  logic [c_ptr_w-1:0] w_mem_idx;
  logic [c_cnt_w-1:0] w_count_nxt;
  logic [WIDTH-1:0]   w_out_nxt;
  logic               w_load_nxt;
  logic               w_err_set;

`ifdef RETURN_STACK_WRAP_EN
  logic [c_ptr_w-1:0] r_base;
  logic               w_base_adv;

  assign w_base = r_base;
`else
  // Without wrap the stack always starts at entry 0.
  assign w_base = '0;
`endif

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == c_cnt_full);

  // Physical slot addressing. When count == DEPTH the low bits of count are
  // zero, so w_wr_idx lands on the base (the oldest entry) and w_top_idx on
  // base-1 (the newest entry); both wrap naturally in c_ptr_w bits.
  always_comb begin
    w_cnt_lo  = r_count[c_ptr_w-1:0];
    w_wr_idx  = w_base + w_cnt_lo;
    w_top_idx = w_wr_idx - c_ptr_one;
  end

  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_wr_idx;
    w_count_nxt = r_count;
    w_out_nxt   = r_out;
    w_load_nxt  = 1'b0;
    w_err_set   = 1'b0;
`ifdef RETURN_STACK_WRAP_EN
    w_base_adv  = 1'b0;
`endif

    if (push && pop) begin
      // Combined call/return: always yields an address, never an error.
      w_load_nxt = 1'b1;
      if (w_empty) begin
        // Nothing stored: forward the pushed address straight through.
        w_out_nxt = in;
      end else begin
        // Replace the top entry; count is unchanged.
        w_out_nxt = r_mem[w_top_idx];
        w_mem_we  = 1'b1;
        w_mem_idx = w_top_idx;
      end
    end else if (push) begin
      if (!w_full) begin
        w_mem_we    = 1'b1;
        w_mem_idx   = w_wr_idx;
        w_count_nxt = r_count + c_cnt_one;
      end else begin
`ifdef RETURN_STACK_WRAP_EN
        // Overwrite the oldest entry (at the base) and advance the base so
        // the new value becomes the top; count stays saturated.
        w_mem_we   = 1'b1;
        w_mem_idx  = w_wr_idx;
        w_base_adv = 1'b1;
`else
        w_err_set  = 1'b1;
`endif
      end
    end else if (pop) begin
      if (!w_empty) begin
        w_out_nxt   = r_mem[w_top_idx];
        w_count_nxt = r_count - c_cnt_one;
        w_load_nxt  = 1'b1;
      end else begin
        w_err_set = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_mem_we) begin
      r_mem[w_mem_idx] <= in;
    end
  end

`ifdef RETURN_STACK_WRAP_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_base <= '0;
    end else if (w_base_adv) begin
      r_base <= r_base + c_ptr_one;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Control / output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_count <= '0;
      r_out   <= '0;
      r_load  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_out   <= w_out_nxt;
      r_load  <= w_load_nxt;
      r_err   <= r_err | w_err_set;
    end
  end

  assign out   = r_out;
  assign load  = r_load;
  assign count = r_count;
  assign empty = w_empty;
  assign full  = w_full;
  assign err   = r_err;

endmodule
`default_nettype wire
